// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex display driver: scans NUM_DIGITS common-anode 7-segment digits
// with frame-synchronous value load, leading-zero blanking, per-digit blink and decimal points.
module hex_display_scanner #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLINK_DIV  = 12500000
) (
  input  logic                      CLOCK_50,
  input  logic                      RESET,
  input  logic [4*NUM_DIGITS-1:0]   VALUE,
  input  logic                      LOAD,
  input  logic                      LZ_EN,
  input  logic [NUM_DIGITS-1:0]     BLINK_MASK,
  input  logic [NUM_DIGITS-1:0]     DP,
  output logic [0:6]                SEG,
  output logic                      SEG_DP,
  output logic [NUM_DIGITS-1:0]     DIG,
  output logic                      FRAME,
  output logic                      LOAD_PEND
);

  localparam int unsigned VAL_W   = 4 * NUM_DIGITS;
  localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
  localparam int unsigned BLINK_W = $clog2(BLINK_DIV);
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]         SEG_BLANK  = 7'b1111111;

  logic [SCAN_W-1:0]     r_scan_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [BLINK_W-1:0]    r_blink_cnt;
  logic                  r_blink_on;
  logic [VAL_W-1:0]      r_pend;
  logic [VAL_W-1:0]      r_disp;
  logic                  r_load_pend;
  logic [0:6]            r_seg;
  logic                  r_seg_dp;
  logic [NUM_DIGITS-1:0] r_dig;

  logic                  w_tick;
  logic                  w_frame;
  logic [3:0]            w_nib;
  logic                  w_lz_blank;
  logic                  w_blink_bit;
  logic                  w_dp_bit;
  logic                  w_blink_off;

  // Active-low a..g pattern, bit 6 = segment a.
  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  assign w_tick  = (r_scan_cnt == SCAN_LAST);
  assign w_frame = w_tick && (r_idx == IDX_LAST);

  // Digit dwell counter and scan index.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else if (w_tick) begin
      r_scan_cnt <= '0;
      r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
    end
  end

  // Free-running blink half-period counter; phase starts ON.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_blink_on  <= ~r_blink_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
    end
  end

  // Double buffer: a load landing on the frame cycle still promotes the older pending value.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_pend      <= '0;
      r_disp      <= '0;
      r_load_pend <= 1'b0;
    end else begin
      if (w_frame && r_load_pend) begin
        r_disp <= r_pend;
      end
      if (LOAD) begin
        r_pend      <= VALUE;
        r_load_pend <= 1'b1;
      end else if (w_frame) begin
        r_load_pend <= 1'b0;
      end
    end
  end

  // Select the current digit and work out whether every digit from it upward is zero.
  always_comb begin
    logic zero_above;
    zero_above  = 1'b1;
    w_nib       = 4'h0;
    w_lz_blank  = 1'b0;
    w_blink_bit = 1'b0;
    w_dp_bit    = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (r_disp[4*i +: 4] == 4'h0);
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_disp[4*i +: 4];
        w_lz_blank  = LZ_EN && zero_above && (i != 0);
        w_blink_bit = BLINK_MASK[i];
        w_dp_bit    = DP[i];
      end
    end
  end

  assign w_blink_off = ~r_blink_on & w_blink_bit;

  // Pin drivers, one cycle behind the scan index.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_seg    <= SEG_BLANK;
      r_seg_dp <= 1'b1;
      r_dig    <= '1;
    end else begin
      r_seg    <= (w_lz_blank || w_blink_off) ? SEG_BLANK : f_decode(w_nib);
      r_seg_dp <= w_blink_off | ~w_dp_bit;
      r_dig    <= ~(NUM_DIGITS'(1) << r_idx);
    end
  end

  assign SEG       = r_seg;
  assign SEG_DP    = r_seg_dp;
  assign DIG       = r_dig;
  assign FRAME     = w_frame;
  assign LOAD_PEND = r_load_pend;

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Parametrised, time-multiplexed hex display driver for NUM_DIGITS common-anode 7-segment digits, driven through one shared segment bus plus per-digit enables.
- Successor to the combinational per-digit hex decoder. Adds:
  - frame-synchronous double-buffered value load;
  - leading-zero suppression;
  - per-digit blink;
  - decimal points.
- Sits between user logic (switches, counters) and board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- SCAN_DIV, 50000, clock cycles each digit stays selected (>=2).
- BLINK_DIV, 12500000, clock cycles per blink half-period (>=2).

Ports:
- CLOCK_50  in   1  system clock, all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- VALUE  in  4*NUM_DIGITS  hex nibbles; digit i = VALUE[4i+3:4i], digit 0 least significant.
- LOAD  in  1  one-cycle strobe; captures VALUE into pending buffer.
- LZ_EN  in  1  1 = suppress leading zeros.
- BLINK_MASK  in  NUM_DIGITS  bit i = 1 makes digit i blink.
- DP  in  NUM_DIGITS  bit i = 1 lights decimal point of digit i.
- SEG  out  [0:6]  active-low segments; SEG[0]=a … SEG[6]=g.
- SEG_DP  out  1  active-low decimal point.
- DIG  out  NUM_DIGITS  active-low one-hot digit enable.
- FRAME  out  1  one-cycle pulse at end of each full scan frame.
- LOAD_PEND  out  1  pending value not yet shown.

Behaviour:
- Reset values:
  - scan counter 0, digit index 0;
  - blink counter 0, blink phase ON;
  - display and pending registers 0; LOAD_PEND 0, FRAME 0;
  - SEG = 1111111, SEG_DP = 1, DIG = all ones.
- Reset is asynchronous and may assert at any time. Mid-scan or mid-load, all state returns to reset values immediately and any pending load is discarded.
- Scan:
  - scan counter runs 0..SCAN_DIV-1; tick = (counter == SCAN_DIV-1);
  - on tick, counter returns to 0 and index advances, wrapping N-1 -> 0;
  - FRAME = 1 exactly in the cycle whose tick wraps the index N-1 -> 0 (combinational from registered state).
- Outputs:
  - SEG, SEG_DP and DIG are registered; each reflects the current index and display register one cycle later;
  - DIG has exactly one 0, at position index (after first post-reset clock).
- Load (double buffering):
  - LOAD = 1: pending <= VALUE, LOAD_PEND <= 1;
  - at a FRAME cycle with LOAD_PEND = 1: display <= pending, LOAD_PEND <= 0;
  - LOAD and FRAME in the same cycle: display takes the old pending (if LOAD_PEND was 1), pending takes VALUE, LOAD_PEND = 1;
  - multiple LOADs within one frame: last one wins.
- Decode (active-low, a..g):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110;
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111;
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000;
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000.
- Leading-zero blanking:
  - when LZ_EN = 1, digit i (i > 0) is blanked if display digits i..N-1 are all 0;
  - digit 0 is never LZ-blanked;
  - DP is unaffected by LZ.
- Blink:
  - blink counter 0..BLINK_DIV-1 free-runs; phase toggles at terminal count;
  - in OFF phase, digits with BLINK_MASK[i] = 1 output SEG = 1111111 and SEG_DP = 1, while DIG still scans;
  - BLINK_MASK, LZ_EN and DP are sampled live, not double-buffered.
- Blanked segments = 1111111.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=64.
- Reset: hold RESET 3 cycles, then release → during reset SEG=1111111, DIG=1111. First clock after release: DIG=1110, SEG=0000001. DIG=1101 appears 4 cycles later. FRAME pulses every 16 cycles.
- Load sync: LOAD with VALUE=16'h1A8F mid-frame → LOAD_PEND=1 and SEG unchanged until the FRAME cycle. Next frame shows digits 0..3 = F, 8, A, 1 (0111000, 0000000, 0001000, 1001111). LOAD_PEND=0 after FRAME.
- Collision: LOAD(16'h0001) in the FRAME cycle while 16'h2222 is pending → 2222 displayed; 0001 stays pending and is shown one frame later.
- Leading zeros: VALUE=16'h0005, LZ_EN=1 → digits 3..1 = 1111111, digit 0 = 0100100. VALUE=0000 → digit 0 = 0000001, others blank. LZ_EN=0 → all four shown.
- Blink/DP: BLINK_MASK=0010, DP=0010 → digit 1 is blank with SEG_DP=1 for 64 cycles, then lit with SEG_DP=0 for 64 cycles. Other digits are unaffected.
- Async reset mid-frame: assert RESET between clock edges with a load pending → outputs immediately go to reset values; LOAD_PEND=0; display returns to 0.
